// File: rtl/port_wr_frontend_if.sv
`default_nettype none
// ============================================================================
// Module   : port_wr_frontend_if
// Brief    : Port-word input, matcher request/response and SRAM write-path bus.
// Revision : 1.0
// ============================================================================
interface port_wr_frontend_if;
  logic        wr_vld;
  logic        wr_sop;
  logic [15:0] wr_data;
  logic [3:0]  new_dest_port;
  logic [8:0]  new_length;
  logic        match_enable;
  logic        viscous;
  logic        match_end;
  logic [4:0]  matching_best_sram;
  logic        xfer_valid;
  logic        xfer_ready;
  logic [4:0]  xfer_sram;
  logic [15:0] xfer_data;
  logic        xfer_last;
  logic [15:0] drop_count;

  modport master (
    output wr_vld, wr_sop, wr_data, match_end, matching_best_sram, xfer_ready,
    input  new_dest_port, new_length, match_enable, viscous,
           xfer_valid, xfer_sram, xfer_data, xfer_last, drop_count
  );

  modport slave (
    input  wr_vld, wr_sop, wr_data, match_end, matching_best_sram, xfer_ready,
    output new_dest_port, new_length, match_enable, viscous,
           xfer_valid, xfer_sram, xfer_data, xfer_last, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/port_wr_frontend.sv
`default_nettype none
// ============================================================================
// Module   : port_wr_frontend
// Brief    : Buffers port packets, requests an SRAM from the matcher, streams words out.
// Revision : 1.0
// ============================================================================
module port_wr_frontend #(
  parameter int PORT_IDX       = 0,
  parameter int MATCH_TIMEOUT  = 255,
  parameter int VISCOUS_WINDOW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  port_wr_frontend_if.slave bus
);
  localparam int TMO_W = $clog2(MATCH_TIMEOUT + 1);
  localparam int WIN_W = $clog2(VISCOUS_WINDOW + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MATCH_TIMEOUT - 1);
  localparam logic [WIN_W-1:0] WIN_MAX  = WIN_W'(VISCOUS_WINDOW);

  if (PORT_IDX < 0 || PORT_IDX > 15) begin : g_port_idx_range
    $error("port_wr_frontend: PORT_IDX out of range");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MATCH = 2'd1, S_XFER = 2'd2} state_e;

  logic [15:0] mem_q [64];
  logic [12:0] hfifo_q [4];
  logic [6:0]  wptr_q, wptr_d, cptr_q, cptr_d, rptr_q;
  logic [2:0]  hwp_q, hwp_d, hrp_q;
  logic        open_q, open_d;
  logic [8:0]  cnt_q, cnt_d, len_q, len_d;
  logic [3:0]  dest_q, dest_d;
  logic [15:0] drop_q, drop_d;

  state_e           state_q;
  logic [TMO_W-1:0] tmo_q;
  logic [WIN_W-1:0] win_q;
  logic [8:0]       idx_q;
  logic [3:0]       new_dest_q;
  logic [8:0]       new_len_q;
  logic             match_enable_q, viscous_q;
  logic             xfer_valid_q, xfer_last_q;
  logic [4:0]       xfer_sram_q;
  logic [15:0]      xfer_data_q;

  logic        hdr_in, hdr_ok, hfull, hempty, mem_we, hdr_push, rd_drop;
  logic [8:0]  hdr_len;
  logic [6:0]  occ, free_words;
  logic [5:0]  mem_waddr;
  logic [1:0]  wr_drops, drop_inc;
  logic [16:0] drop_sum;
  logic [12:0] hdr_head;

  assign hdr_in     = bus.wr_vld & bus.wr_sop;
  assign hdr_len    = bus.wr_data[15:7];
  assign occ        = cptr_q - rptr_q;
  assign free_words = 7'd64 - occ;
  assign hfull      = (hwp_q - hrp_q) == 3'd4;
  assign hempty     = hwp_q == hrp_q;
  assign hdr_head   = hfifo_q[hrp_q[1:0]];
  assign hdr_ok     = (hdr_len >= 9'd2) && (hdr_len <= 9'd64) &&
                      (hdr_len <= {2'b00, free_words}) && !hfull;

  // A new header always restarts from the committed pointer, which also
  // discards the uncommitted tail of an interrupted packet.
  always_comb begin
    wptr_d    = wptr_q;
    cptr_d    = cptr_q;
    open_d    = open_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    dest_d    = dest_q;
    mem_we    = 1'b0;
    mem_waddr = wptr_q[5:0];
    hdr_push  = 1'b0;
    wr_drops  = 2'd0;
    if (hdr_in) begin
      wptr_d = cptr_q;
      if (open_q) wr_drops = 2'd1;
      if (hdr_ok) begin
        mem_we    = 1'b1;
        mem_waddr = cptr_q[5:0];
        wptr_d    = cptr_q + 7'd1;
        cnt_d     = 9'd1;
        len_d     = hdr_len;
        dest_d    = bus.wr_data[3:0];
        open_d    = 1'b1;
      end else begin
        open_d   = 1'b0;
        wr_drops = wr_drops + 2'd1;
      end
    end else if (bus.wr_vld && open_q) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + 7'd1;
      cnt_d  = cnt_q + 9'd1;
      if (cnt_q + 9'd1 == len_q) begin
        cptr_d   = wptr_q + 7'd1;
        hdr_push = 1'b1;
        open_d   = 1'b0;
      end
    end
    hwp_d = hdr_push ? hwp_q + 3'd1 : hwp_q;
  end

  // Up to three drops can land in one cycle: abort, rejected header, timeout.
  assign rd_drop  = (state_q == S_MATCH) && !bus.match_end && (tmo_q == TMO_LAST);
  assign drop_inc = wr_drops + {1'b0, rd_drop};
  assign drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
  assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      cptr_q <= '0;
      hwp_q  <= '0;
      open_q <= 1'b0;
      cnt_q  <= '0;
      len_q  <= '0;
      dest_q <= '0;
      drop_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      cptr_q <= cptr_d;
      hwp_q  <= hwp_d;
      open_q <= open_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      dest_q <= dest_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= bus.wr_data;
    if (hdr_push) hfifo_q[hwp_q[1:0]] <= {dest_q, len_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rptr_q         <= '0;
      hrp_q          <= '0;
      tmo_q          <= '0;
      win_q          <= WIN_MAX;
      idx_q          <= '0;
      new_dest_q     <= '0;
      new_len_q      <= '0;
      match_enable_q <= 1'b0;
      viscous_q      <= 1'b0;
      xfer_valid_q   <= 1'b0;
      xfer_last_q    <= 1'b0;
      xfer_sram_q    <= '0;
      xfer_data_q    <= '0;
    end else begin
      match_enable_q <= 1'b0;
      if (win_q < WIN_MAX) win_q <= win_q + WIN_W'(1);
      case (state_q)
        S_IDLE: begin
          if (!hempty) begin
            new_dest_q     <= hdr_head[12:9];
            new_len_q      <= hdr_head[8:0];
            match_enable_q <= 1'b1;
            viscous_q      <= win_q < WIN_MAX;
            tmo_q          <= '0;
            state_q        <= S_MATCH;
          end
        end
        S_MATCH: begin
          // match_end is checked first so it beats a coincident timeout.
          if (bus.match_end) begin
            xfer_sram_q  <= bus.matching_best_sram;
            hrp_q        <= hrp_q + 3'd1;
            win_q        <= '0;
            xfer_valid_q <= 1'b1;
            xfer_data_q  <= mem_q[rptr_q[5:0]];
            xfer_last_q  <= new_len_q == 9'd1;
            idx_q        <= '0;
            state_q      <= S_XFER;
          end else if (tmo_q == TMO_LAST) begin
            rptr_q  <= rptr_q + new_len_q[6:0];
            hrp_q   <= hrp_q + 3'd1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_XFER: begin
          if (xfer_valid_q && bus.xfer_ready) begin
            rptr_q <= rptr_q + 7'd1;
            if (xfer_last_q) begin
              xfer_valid_q <= 1'b0;
              xfer_last_q  <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              xfer_data_q <= mem_q[rptr_q[5:0] + 6'd1];
              idx_q       <= idx_q + 9'd1;
              xfer_last_q <= (idx_q + 9'd2) == new_len_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.new_dest_port = new_dest_q;
  assign bus.new_length    = new_len_q;
  assign bus.match_enable  = match_enable_q;
  assign bus.viscous       = viscous_q;
  assign bus.xfer_valid    = xfer_valid_q;
  assign bus.xfer_sram     = xfer_sram_q;
  assign bus.xfer_data     = xfer_data_q;
  assign bus.xfer_last     = xfer_last_q;
  assign bus.drop_count    = drop_q;
endmodule
`default_nettype wire

// File: doc/port_wr_frontend.md
PORT_WR_FRONTEND -- requirements
Module: port_wr_frontend

Interface
REQ-001 Parameter PORT_IDX, default 0, port number 0..15 for this front end.
REQ-002 Parameter MATCH_TIMEOUT, default 255, maximum number of MATCH cycles before the packet is dropped.
REQ-003 Parameter VISCOUS_WINDOW, default 16, number of cycles after a match in which the next match may reuse the previous SRAM.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 wr_vld  input  1  a valid port word is present this cycle.
REQ-007 wr_sop  input  1  this word is a header; qualified by wr_vld.
REQ-008 wr_data  input  16  port word; header layout: [3:0] dest port, [6:4] priority (carried, unused), [15:7] length in words including the header.
REQ-009 new_dest_port  output  4  dest port sent to the matcher.
REQ-010 new_length  output  9  packet length sent to the matcher.
REQ-011 match_enable  output  1  one-cycle match request.
REQ-012 viscous  output  1  permits the matcher to reuse the previous SRAM.
REQ-013 match_end  input  1  the matcher has selected an SRAM.
REQ-014 matching_best_sram  input  5  SRAM selected by the matcher; valid while match_end=1.
REQ-015 xfer_valid  output  1  a word is offered to the SRAM write path.
REQ-016 xfer_ready  input  1  the SRAM write path accepts the offered word.
REQ-017 xfer_sram  output  5  target SRAM index.
REQ-018 xfer_data  output  16  word being written.
REQ-019 xfer_last  output  1  marks the final word of the packet.
REQ-020 drop_count  output  16  saturating count of dropped packets.

Function
REQ-021 The data FIFO SHALL be 64x16 with a write pointer, a committed pointer and a read pointer, all 7 bits wide including the wrap bit.
REQ-022 The header FIFO SHALL hold 4 entries of {dest[3:0], length[8:0]}.
REQ-023 On a header (wr_vld & wr_sop), the packet SHALL be dropped if length<2, or length>64, or length > 64 minus committed occupancy, or the header FIFO is full; otherwise the header word is stored and the received-word counter is set to 1.
REQ-024 Each later wr_vld word SHALL be stored while the counter is below length; when the counter reaches length, the committed pointer is set to the write pointer and the header is pushed.
REQ-025 Words with wr_sop=0 that arrive while no packet is open, or after the counter has reached length, SHALL be discarded.
REQ-026 A header that arrives while a packet is still incomplete SHALL roll the write pointer back to the committed pointer, increment drop_count, and then be evaluated as a new packet per REQ-023.
REQ-027 The read-side FSM SHALL have three states: IDLE, MATCH and XFER.
REQ-028 IDLE -> MATCH when the header FIFO is not empty: match_enable pulses for 1 cycle, and new_dest_port/new_length are loaded in that cycle and held until the next request.
REQ-029 In the cycle match_enable is asserted, viscous SHALL be 1 if fewer than VISCOUS_WINDOW cycles have passed since the last accepted match_end, else 0.
REQ-030 MATCH -> XFER when match_end=1: matching_best_sram is captured into xfer_sram, the header is popped, and the window counter is cleared.
REQ-031 MATCH -> IDLE when MATCH_TIMEOUT cycles pass without match_end: the read pointer advances by length, the header is popped, and drop_count is incremented.
REQ-032 If match_end and the timeout occur in the same cycle, match_end SHALL win.
REQ-033 In XFER, xfer_valid SHALL be registered and rise the cycle after match_end is sampled.
REQ-034 The word at the read pointer is presented on xfer_data; the read pointer and the word index advance only when xfer_valid & xfer_ready.
REQ-035 xfer_last SHALL be 1 when word index = length-1; XFER -> IDLE on the accepted last word, with xfer_valid low in the following cycle.
REQ-036 xfer_valid and xfer_data SHALL stay stable while xfer_ready=0.
REQ-037 The write side SHALL keep accepting port words during MATCH and XFER, and a simultaneous FIFO read and write SHALL lose no word.
REQ-038 At least one idle cycle SHALL separate match_end from the next match_enable.
REQ-039 drop_count SHALL saturate at 16'hFFFF.

Reset
REQ-040 When rst_n=0 at a clock edge: FSM=IDLE; all pointers, counters and both FIFOs empty.
REQ-041 Reset values: match_enable=0, viscous=0, new_dest_port=0, new_length=0, xfer_valid=0, xfer_sram=0, xfer_data=0, xfer_last=0, drop_count=0.
REQ-042 An in-flight packet SHALL be discarded on reset without any further xfer_valid.
REQ-043 The window counter SHALL reset to VISCOUS_WINDOW, so that viscous=0 on the first match.

Verification
REQ-044 Send a 4-word packet with dest=3; return match_end after 5 cycles with sram=9 -> one match_enable pulse with new_dest_port=3 and new_length=4; 4 xfer words to sram 9 in order; xfer_last on word 4.
REQ-045 Send two back-to-back packets; return the second match_end 3 cycles after the first transfer ends -> viscous=0 on the first request and 1 on the second.
REQ-046 Send a header of length 8 followed by only 3 data words, then a new header -> drop_count=1, no xfer of the partial words, and the second packet delivered intact.
REQ-047 Never assert match_end -> after 255 MATCH cycles drop_count increments, the read pointer skips length words, and the next packet is matched.
REQ-048 Hold xfer_ready low for 10 cycles mid-transfer -> xfer_data stable throughout, no word lost or duplicated.
REQ-049 Fill the FIFO with 60 committed words, then send a header of length 8 -> drop; send a header of length 70 -> drop; drop_count=2.
